and_or_arbiter: RTL and testbench



---
 rtl/and_or_arbiter_if.sv | 23 ++
 rtl/and_or_arbiter.sv | 108 ++++++++++
 tb/tb_and_or_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/and_or_arbiter_if.sv
// Request/operand bus between four clients and the shared and-or unit.
// The arbiter takes the slave modport; clients (or a bench) take the master modport.
interface and_or_arbiter_if #(
  parameter int WIDTH = 1
);
  logic [3:0]          req;
  logic [16*WIDTH-1:0] opnd;
  logic [3:0]          gnt;
  logic [3:0]          ack;
  logic [WIDTH-1:0]    result;
  logic                busy;
  logic [7:0]          op_cnt;

  modport master (
    output req, opnd,
    input  gnt, ack, result, busy, op_cnt
  );

  modport slave (
    input  req, opnd,
    output gnt, ack, result, busy, op_cnt
  );
endinterface

// File: rtl/and_or_arbiter.sv
// Round-robin arbiter sharing one registered (a&b)|(c&d) unit among four requesters.
// Each grant runs IDLE -> EVAL -> RESP; ack pulses in RESP, so one operation per three cycles.
module and_or_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  and_or_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       sel;
  logic [1:0]       win;
  logic             found;
  logic [WIDTH-1:0] opa, opb, opc, opd;
  logic [3:0]       gnt_q;
  logic [3:0]       ack_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic [7:0]       cnt_q;

  // Search starts one past the last winner, so every requester is reached within four slots.
  always_comb begin
    win   = ptr + 2'd1;
    found = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      if (!found && bus.req[ptr + 2'(n)]) begin
        win   = ptr + 2'(n);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 2'd3;
      sel      <= 2'd0;
      gnt_q    <= 4'd0;
      ack_q    <= 4'd0;
      result_q <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= 8'd0;
      opa      <= '0;
      opb      <= '0;
      opc      <= '0;
      opd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel    <= win;
            gnt_q  <= 4'b0001 << win;
            busy_q <= 1'b1;
            opa    <= bus.opnd[(int'(win) * 4 + 0) * WIDTH +: WIDTH];
            opb    <= bus.opnd[(int'(win) * 4 + 1) * WIDTH +: WIDTH];
            opc    <= bus.opnd[(int'(win) * 4 + 2) * WIDTH +: WIDTH];
            opd    <= bus.opnd[(int'(win) * 4 + 3) * WIDTH +: WIDTH];
          end
        end
        EVAL: begin
          result_q <= (opa & opb) | (opc & opd);
          ack_q    <= gnt_q;
        end
        RESP: begin
          // result_q is deliberately kept so the client can still read it after ack.
          ack_q  <= 4'd0;
          gnt_q  <= 4'd0;
          busy_q <= 1'b0;
          ptr    <= sel;
          cnt_q  <= cnt_q + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.op_cnt = cnt_q;
endmodule

// File: tb/tb_and_or_arbiter.sv
// Bench for and_or_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level round-robin model.
module tb_and_or_arbiter;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  and_or_arbiter_if #(.WIDTH(W)) bus ();

  and_or_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit auto_drop = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: per transaction, age 0 = granted, age 1 = acknowledging, -1 = nothing in flight.
  int               age     = -1;
  int               last    = 3;
  int               cur     = 0;
  int               done    = 0;
  bit               found;
  logic [W-1:0]     la, lb, lc, ld;
  logic [3:0]       exp_gnt  = 4'd0;
  logic [3:0]       exp_ack  = 4'd0;
  logic [W-1:0]     exp_res  = '0;
  logic             exp_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age = -1; last = 3; cur = 0; done = 0; exp_res = '0;
    end else if (age < 0) begin
      if (bus.req != 4'd0) begin
        found = 1'b0;
        for (int n = 1; n <= 4; n++) begin
          if (!found && bus.req[(last + n) % 4]) begin
            cur   = (last + n) % 4;
            found = 1'b1;
          end
        end
        la  = bus.opnd[(4 * cur + 0) * W +: W];
        lb  = bus.opnd[(4 * cur + 1) * W +: W];
        lc  = bus.opnd[(4 * cur + 2) * W +: W];
        ld  = bus.opnd[(4 * cur + 3) * W +: W];
        age = 0;
      end
    end else if (age == 0) begin
      exp_res = (la & lb) | (lc & ld);
      age     = 1;
    end else begin
      last = cur;
      done = (done + 1) % 256;
      age  = -1;
    end
    exp_gnt  = (age >= 0) ? 4'(1 << cur) : 4'd0;
    exp_ack  = (age == 1) ? 4'(1 << cur) : 4'd0;
    exp_busy = (age >= 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt",    32'(bus.gnt),    32'(exp_gnt));
      chk("ack",    32'(bus.ack),    32'(exp_ack));
      chk("result", 32'(bus.result), 32'(exp_res));
      chk("busy",   32'(bus.busy),   32'(exp_busy));
      chk("op_cnt", 32'(bus.op_cnt), 32'(done));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (auto_drop) bus.req = bus.req & ~bus.ack;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, b, c, d);
    bus.opnd[(4 * i + 0) * W +: W] = a;
    bus.opnd[(4 * i + 1) * W +: W] = b;
    bus.opnd[(4 * i + 2) * W +: W] = c;
    bus.opnd[(4 * i + 3) * W +: W] = d;
  endtask

  int ack_idx[8];
  int ack_time[8];
  int n_ack;
  int acks;

  initial begin
    bus.req  = 4'd0;
    bus.opnd = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt",    32'(bus.gnt),    32'd0);
    chk("rst_ack",    32'(bus.ack),    32'd0);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_op_cnt", 32'(bus.op_cnt), 32'd0);
    rst_n = 1'b1;

    // Single request from requester 2: (C&A)|(3&6) = 8|2 = A.
    set_ops(2, 4'hC, 4'hA, 4'h3, 4'h6);
    bus.req = 4'b0100;
    tick();
    chk("single_gnt",  32'(bus.gnt),  32'b0100);
    chk("single_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("single_ack",    32'(bus.ack),    32'b0100);
    chk("single_result", 32'(bus.result), 32'hA);
    tick();
    chk("single_cnt",  32'(bus.op_cnt), 32'd1);
    chk("single_idle", 32'(bus.gnt),    32'd0);
    chk("result_hold", 32'(bus.result), 32'hA);

    // Serve requester 1 so it is last, then 3 must beat 1.
    bus.req = 4'b0010;
    tick(); tick(); tick();
    bus.req = 4'b1010;
    tick();
    chk("rot_first", 32'(bus.gnt), 32'b1000);
    tick(); tick(); tick();
    chk("rot_second", 32'(bus.gnt), 32'b0010);
    tick(); tick();

    // Operand change after grant: (F&3)|(0&5) = 3; the new operands would give F.
    set_ops(2, 4'hF, 4'h3, 4'h0, 4'h5);
    bus.req = 4'b0100;
    tick();
    set_ops(2, 4'h0, 4'h0, 4'hF, 4'hF);
    tick();
    chk("midop_ack",    32'(bus.ack),    32'b0100);
    chk("midop_result", 32'(bus.result), 32'h3);
    tick();

    // Request dropped after grant still completes: (5&5)|(A&A) = F.
    set_ops(2, 4'h5, 4'h5, 4'hA, 4'hA);
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    tick();
    chk("drop_ack",    32'(bus.ack),    32'b0100);
    chk("drop_result", 32'(bus.result), 32'hF);
    tick();

    // All four held from reset: grant order 0,1,2,3,0 with acks 3 cycles apart.
    rst_n     = 1'b0;
    auto_drop = 1'b0;
    bus.req   = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    n_ack = 0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (bus.ack != 4'd0 && n_ack < 8) begin
        for (int b = 0; b < 4; b++) if (bus.ack[b]) ack_idx[n_ack] = b;
        ack_time[n_ack] = t;
        n_ack++;
      end
    end
    chk("all_ack_count", 32'(n_ack), 32'd5);
    for (int k = 0; k < 5 && k < n_ack; k++) begin
      chk("all_order", 32'(ack_idx[k]), 32'(k % 4));
      if (k > 0) chk("all_spacing", 32'(ack_time[k] - ack_time[k - 1]), 32'd3);
    end
    bus.req   = 4'b0000;
    auto_drop = 1'b1;
    tick(); tick(); tick();

    // Reset during EVAL: outputs clear before the next edge, no ack, pointer back to 3.
    bus.req = 4'b0100;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt",    32'(bus.gnt),    32'd0);
    chk("arst_ack",    32'(bus.ack),    32'd0);
    chk("arst_busy",   32'(bus.busy),   32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_op_cnt", 32'(bus.op_cnt), 32'd0);
    bus.req = 4'b0101;
    #1 rst_n = 1'b1;
    tick();
    chk("abort_gnt", 32'(bus.gnt), 32'b0001);
    chk("abort_ack", 32'(bus.ack), 32'd0);

    // 256 operations bring op_cnt back to 0.
    auto_drop = 1'b0;
    bus.req   = 4'b1111;
    acks      = 0;
    for (int t = 0; t < 1000 && acks < 256; t++) begin
      if (bus.ack != 4'd0) begin
        acks++;
        if (acks == 256) chk("cnt_255", 32'(bus.op_cnt), 32'd255);
      end
      if (acks < 256) tick();
    end
    chk("wrap_acks", 32'(acks), 32'd256);
    tick();
    chk("cnt_wrap", 32'(bus.op_cnt), 32'd0);

    // Random traffic: requesters raise at will, may drop before grant, always drop on ack.
    auto_drop = 1'b1;
    for (int t = 0; t < 600; t++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (!bus.req[i] && $urandom_range(3) == 0) bus.req[i] = 1'b1;
        else if (bus.req[i] && !bus.gnt[i] && $urandom_range(7) == 0) bus.req[i] = 1'b0;
      end
      bus.opnd = {$urandom(), $urandom()};
    end
    bus.req = 4'b0000;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
